pc_fetch_queue: RTL and testbench

- Parametrised successor to the pre-IF/IF PC pipeline register.
- Replaces the single stall/flush register with a DEPTH-entry FIFO that carries {pc, exception_type}, using valid/ready handshakes on both sides.
- Sits between PC generation (producer) and the IF stage / instruction SRAM request logic (consumer), so PC generation can run ahead while IF stalls.
- Flush empties the queue in one cycle, as on exception or branch redirect.

---
 rtl/pc_fetch_queue_if.sv | 30 +++
 rtl/pc_fetch_queue.sv | 67 ++++++
 tb/tb_pc_fetch_queue.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_queue_if.sv
// Valid/ready bundle between PC generation (producer) and the IF-stage fetch queue.
// The consumer-side signals and the occupancy count travel in the same bundle.
interface pc_fetch_queue_if #(
  parameter int PC_W  = 32,
  parameter int EXC_W = 32,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [PC_W-1:0]  in_pc;
  logic [EXC_W-1:0] in_exc;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_pc;
  logic [EXC_W-1:0] out_exc;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_pc, in_exc, out_ready,
    input  in_ready, out_valid, out_pc, out_exc, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_exc, out_ready,
    output in_ready, out_valid, out_pc, out_exc, count
  );
endinterface

// File: rtl/pc_fetch_queue.sv
// DEPTH-entry circular FIFO of {pc, exception_type} between PC generation and IF.
// Lets PC generation run ahead while IF stalls; flush empties it in one cycle.
module pc_fetch_queue #(
  parameter int PC_W             = 32,
  parameter int EXC_W            = 32,
  parameter int DEPTH            = 4,
  parameter int PUSH_ON_FULL_POP = 1
) (
  input logic             clk,
  input logic             rst,
  pc_fetch_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + EXC_W;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return p + AW'(1);
  endfunction

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          empty;
  logic          rdy;
  logic          push;
  logic          pop;

  always_comb begin
    full  = (cnt == CW'(DEPTH));
    empty = (cnt == '0);
    rdy   = 1'b0;
    if (!rst)
      rdy = !full || ((PUSH_ON_FULL_POP != 0) && q.out_ready);
    push  = q.in_valid && rdy && !q.flush;
    pop   = !empty && q.out_ready && !q.flush;
  end

  assign q.in_ready  = rdy;
  assign q.out_valid = !empty;
  assign q.count     = cnt;
  // Head is read straight from storage and zeroed when empty; no path from in_* to out_*.
  assign {q.out_pc, q.out_exc} = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // On a full push+pop the write slot equals the slot being freed by the pop.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {q.in_pc, q.in_exc};
  end
endmodule

// File: tb/tb_pc_fetch_queue.sv
// Bench for pc_fetch_queue: one instance with PUSH_ON_FULL_POP=1 and one with 0,
// each checked every cycle against a queue-based model plus directed literal checks.
module tb_pc_fetch_queue;
  localparam int PC_W  = 32;
  localparam int EXC_W = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [PC_W-1:0]  in_pc = '0;
  logic [EXC_W-1:0] in_exc = '0;
  logic             out_ready = 1'b0;
  logic             mask0 = 1'b0;
  logic             chk_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  pc_fetch_queue_if #(.PC_W(PC_W), .EXC_W(EXC_W), .DEPTH(DEPTH)) if1 ();
  pc_fetch_queue_if #(.PC_W(PC_W), .EXC_W(EXC_W), .DEPTH(DEPTH)) if0 ();

  assign if1.flush     = flush;
  assign if1.in_valid  = in_valid;
  assign if1.in_pc     = in_pc;
  assign if1.in_exc    = in_exc;
  assign if1.out_ready = out_ready;
  assign if0.flush     = flush;
  assign if0.in_valid  = in_valid & ~mask0;
  assign if0.in_pc     = in_pc;
  assign if0.in_exc    = in_exc;
  assign if0.out_ready = out_ready & ~mask0;

  pc_fetch_queue #(.PC_W(PC_W), .EXC_W(EXC_W), .DEPTH(DEPTH), .PUSH_ON_FULL_POP(1)) u1 (
    .clk(clk), .rst(rst), .q(if1.slave));
  pc_fetch_queue #(.PC_W(PC_W), .EXC_W(EXC_W), .DEPTH(DEPTH), .PUSH_ON_FULL_POP(0)) u0 (
    .clk(clk), .rst(rst), .q(if0.slave));

  logic [1:0]       a_rdy, a_vld, a_iv, a_or;
  logic [PC_W-1:0]  a_pc  [2];
  logic [EXC_W-1:0] a_exc [2];
  logic [2:0]       a_cnt [2];
  assign a_rdy = {if1.in_ready, if0.in_ready};
  assign a_vld = {if1.out_valid, if0.out_valid};
  assign a_iv  = {if1.in_valid, if0.in_valid};
  assign a_or  = {if1.out_ready, if0.out_ready};
  assign a_pc[0] = if0.out_pc;   assign a_pc[1] = if1.out_pc;
  assign a_exc[0] = if0.out_exc; assign a_exc[1] = if1.out_exc;
  assign a_cnt[0] = if0.count;   assign a_cnt[1] = if1.count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one FIFO of {pc,exc} per instance; index k is also the PUSH_ON_FULL_POP value.
  logic [63:0] mq [2][$];
  int          m_sz;
  logic        m_rdy, m_push, m_pop;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst || flush) begin
        mq[k].delete();
      end else begin
        m_sz   = mq[k].size();
        m_rdy  = (m_sz < DEPTH) || (k == 1 && a_or[k]);
        m_pop  = (m_sz > 0) && a_or[k];
        m_push = a_iv[k] && m_rdy;
        if (m_pop)  void'(mq[k].pop_front());
        if (m_push) mq[k].push_back({in_pc, in_exc});
      end
    end
  end

  int          c_sz;
  logic [63:0] c_hd;
  logic        c_rdy;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        c_sz  = mq[k].size();
        c_hd  = (c_sz > 0) ? mq[k][0] : 64'd0;
        c_rdy = !rst && ((c_sz < DEPTH) || (k == 1 && a_or[k]));
        chk($sformatf("cyc%0d_in_ready", k),  64'(a_rdy[k]), 64'(c_rdy));
        chk($sformatf("cyc%0d_out_valid", k), 64'(a_vld[k]), 64'(c_sz > 0));
        chk($sformatf("cyc%0d_out_pc", k),    64'(a_pc[k]),  64'(c_hd[63:32]));
        chk($sformatf("cyc%0d_out_exc", k),   64'(a_exc[k]), 64'(c_hd[31:0]));
        chk($sformatf("cyc%0d_count", k),     64'(a_cnt[k]), 64'(c_sz));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  p, g;
  logic acc;

  initial begin
    // Reset held with a pending push
    in_valid = 1'b1;
    in_pc    = 32'hBFC00000;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_in_ready", 64'(if1.in_ready), 64'd0);
    chk("rst_out_valid", 64'(if1.out_valid), 64'd0);
    chk("rst_out_pc", 64'(if1.out_pc), 64'd0);
    chk("rst_count", 64'(if1.count), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("rst_nothing_queued", 64'(if1.count), 64'd0);

    // Fill then drain
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'hBFC00000 + 32'(4 * i);
      tick();
      chk($sformatf("fill_count%0d", i), 64'(if1.count), 64'(i + 1));
    end
    chk("full_in_ready1", 64'(if1.in_ready), 64'd0);
    chk("full_in_ready0", 64'(if0.in_ready), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_pc%0d", i), 64'(if1.out_pc), 64'(32'hBFC00000 + 32'(4 * i)));
      tick();
    end
    chk("drain_count", 64'(if1.count), 64'd0);
    chk("drain_valid", 64'(if1.out_valid), 64'd0);
    out_ready = 1'b0;

    // Full queue with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'hBFC00000 + 32'(4 * i);
      tick();
    end
    in_pc     = 32'hBFC00010;
    out_ready = 1'b1;
    #1;
    chk("fullpp_in_ready1", 64'(if1.in_ready), 64'd1);
    chk("fullpp_in_ready0", 64'(if0.in_ready), 64'd0);
    tick();
    chk("fullpp_count1", 64'(if1.count), 64'd4);
    chk("fullpp_count0", 64'(if0.count), 64'd3);
    chk("fullpp_head1", 64'(if1.out_pc), 64'(32'hBFC00004));
    out_ready = 1'b0;
    tick();
    chk("late_push_count0", 64'(if0.count), 64'd4);
    chk("late_push_count1", 64'(if1.count), 64'd4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fullpp_order1_%0d", i), 64'(if1.out_pc), 64'(32'hBFC00004 + 32'(4 * i)));
      chk($sformatf("fullpp_order0_%0d", i), 64'(if0.out_pc), 64'(32'hBFC00004 + 32'(4 * i)));
      tick();
    end
    chk("fullpp_empty", 64'(if1.count), 64'd0);
    out_ready = 1'b0;

    // Flush with a concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'hBFC00020 + 32'(4 * i);
      in_exc   = 32'h5;
      tick();
    end
    chk("preflush_count", 64'(if1.count), 64'd3);
    flush     = 1'b1;
    in_pc     = 32'hBFC0002C;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_exc    = '0;
    chk("flush_count1", 64'(if1.count), 64'd0);
    chk("flush_count0", 64'(if0.count), 64'd0);
    chk("flush_valid", 64'(if1.out_valid), 64'd0);
    chk("flush_pc", 64'(if1.out_pc), 64'd0);
    chk("flush_exc", 64'(if1.out_exc), 64'd0);
    tick();
    chk("postflush_count", 64'(if1.count), 64'd0);

    // Reset mid-operation drops entries
    in_valid = 1'b1;
    in_pc    = 32'h00000040;
    tick();
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_count", 64'(if1.count), 64'd0);
    chk("midrst_valid", 64'(if1.out_valid), 64'd0);

    // Streaming across the pointer wrap with alternating out_ready
    mask0 = 1'b1;
    p = 0;
    g = 0;
    for (int c = 0; c < 60 && g < 10; c++) begin
      in_valid  = (p < 10);
      in_pc     = 32'h00000100 + 32'(4 * p);
      in_exc    = (p == 6) ? 32'h1 : 32'h0;
      out_ready = c[0];
      #1;
      if (if1.out_valid && out_ready) begin
        chk($sformatf("wrap_pc%0d", g), 64'(if1.out_pc), 64'(32'h00000100 + 32'(4 * g)));
        chk($sformatf("wrap_exc%0d", g), 64'(if1.out_exc), 64'((g == 6) ? 1 : 0));
        g++;
      end
      acc = in_valid && if1.in_ready;
      tick();
      if (acc) p++;
    end
    chk("wrap_all_out", 64'(g), 64'd10);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("wrap_end_count", 64'(if1.count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
